// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline front end.
// ifid_t is the {pc, instr} pair handed from fetch to decode.
package mips_pkg;

   localparam int          INSTR_W          = 32;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] NOP              = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } ifid_t;

   // Byte address -> word address with the low two bits cleared.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// IF/ID valid/ready channel between the fetch stage (master) and decode (slave).
interface instr_fetch_if;
   import mips_pkg::*;

   logic               ifid_valid;
   logic               ifid_ready;
   logic [INSTR_W-1:0] ifid_instr;
   logic [INSTR_W-1:0] ifid_pc;
   logic [INSTR_W-1:0] ifid_pc_plus4;

   modport master (
      output ifid_valid,
      output ifid_instr,
      output ifid_pc,
      output ifid_pc_plus4,
      input  ifid_ready
   );

   modport slave (
      input  ifid_valid,
      input  ifid_instr,
      input  ifid_pc,
      input  ifid_pc_plus4,
      output ifid_ready
   );

endinterface

// File: rtl/fetch_skid_fifo.sv
// Small circular skid buffer of ifid_t entries that absorbs the cache's one-cycle latency.
// Flush empties it in one clock; the head entry is presented straight from its register.
module fetch_skid_fifo
   import mips_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             enq,
   input  ifid_t            enq_data,
   input  logic             deq,
   output ifid_t            head,
   output logic [CNT_W-1:0] count,
   output logic             empty,
   output logic             full
);

   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             enq_ok;
   logic             deq_ok;
   ifid_t            entries [DEPTH];

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty  = (count_q == '0);
   assign full   = (count_q == CNT_W'(DEPTH));
   assign count  = count_q;
   assign deq_ok = deq && !empty;
   assign enq_ok = enq && (!full || deq_ok);

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         ifid_t entry_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               entry_q <= '0;
            end else if (enq_ok && !flush && wr_ptr_q == PTR_W'(gi)) begin
               entry_q <= enq_data;
            end
         end

         assign entries[gi] = entry_q;
      end
   endgenerate

   assign head = entries[rd_ptr_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         // A pop in the flush cycle is already delivered; everything left is discarded.
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (enq_ok) begin
            wr_ptr_q <= ptr_inc(wr_ptr_q);
         end
         if (deq_ok) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         case ({enq_ok, deq_ok})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// MIPS IF stage: owns the PC, issues one cache read per clock when a skid slot is free,
// and hands {pc, instr} to decode over a valid/ready channel. Redirects flush everything.
module instr_fetch
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic [INSTR_W-1:0] iCacheReadAddr,
   input  logic [INSTR_W-1:0] iCacheReadData,
   input  logic               redirect_valid,
   input  logic [INSTR_W-1:0] redirect_pc,
   instr_fetch_if.master      ifid
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int OCC_W = CNT_W + 1;

   logic [INSTR_W-1:0] pc_q;
   logic [INSTR_W-1:0] inflight_pc_q;
   logic               inflight_q;

   ifid_t              fifo_head;
   ifid_t              fifo_in;
   logic [CNT_W-1:0]   fifo_count;
   logic               fifo_empty;
   logic               fifo_full;
   logic               deq;
   logic               enq;
   logic               issue;
   logic [OCC_W-1:0]   occupancy;

   assign iCacheReadAddr = pc_q;

   assign deq = !fifo_empty && ifid.ifid_ready;
   assign enq = inflight_q && !redirect_valid;

   // Slots that will be taken after this edge if nothing new is issued; an in-flight
   // response already owns its slot, which is what keeps the FIFO from overflowing.
   assign occupancy = OCC_W'(fifo_count) + OCC_W'(inflight_q) - OCC_W'(deq);
   assign issue     = !redirect_valid
                      && !(fifo_full && !deq)
                      && (occupancy < OCC_W'(FIFO_DEPTH));

   always_comb begin
      fifo_in       = '0;
      fifo_in.pc    = inflight_pc_q;
      fifo_in.instr = iCacheReadData;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q          <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else if (redirect_valid) begin
         pc_q       <= word_align(redirect_pc);
         inflight_q <= 1'b0;
      end else if (issue) begin
         pc_q          <= pc_q + 32'd4;
         inflight_q    <= 1'b1;
         inflight_pc_q <= pc_q;
      end else begin
         inflight_q <= 1'b0;
      end
   end

   fetch_skid_fifo #(
      .DEPTH    (FIFO_DEPTH)
   ) u_skid (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (redirect_valid),
      .enq      (enq),
      .enq_data (fifo_in),
      .deq      (deq),
      .head     (fifo_head),
      .count    (fifo_count),
      .empty    (fifo_empty),
      .full     (fifo_full)
   );

   // Outputs read zero while nothing is valid so the reset state is all-zero.
   assign ifid.ifid_valid    = !fifo_empty;
   assign ifid.ifid_pc       = fifo_empty ? '0  : fifo_head.pc;
   assign ifid.ifid_instr    = fifo_empty ? NOP : fifo_head.instr;
   assign ifid.ifid_pc_plus4 = fifo_empty ? '0  : fifo_head.pc + 32'd4;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: a one-cycle cache model plus an in-order delivery
// model that predicts every IF/ID transaction from the fetch/redirect rules.
module tb_instr_fetch;
   import mips_pkg::*;

   localparam int          DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk;
   logic        rst_n;
   logic [31:0] icache_addr;
   logic [31:0] icache_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   instr_fetch_if ifid ();

   instr_fetch #(
      .RESET_PC       (RESET_PC),
      .FIFO_DEPTH     (DEPTH)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .iCacheReadAddr (icache_addr),
      .iCacheReadData (icache_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .ifid           (ifid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'h2001_0002;
         32'h0000_0004: return 32'h2002_0004;
         32'h0000_0008: return 32'h2003_0006;
         32'h0000_0040: return 32'h200F_0012;
         default:       return {a[15:0], ~a[15:0]} ^ {a[31:16], 16'h0};
      endcase
   endfunction

   always @(posedge clk) icache_data <= mem_word(icache_addr);

   int n_checks = 0;
   int n_pass   = 0;
   int n_deliv  = 0;

   // Model state: next pc decode should receive, cycles since the last flush, etc.
   logic [31:0] exp_pc;
   logic [31:0] flush_target;
   int          since;
   logic        all_ready;
   logic        prev_hold;
   logic [31:0] held_pc;
   logic [31:0] held_instr;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
   endtask

   task automatic check_reset_state();
      check("rst_addr",  icache_addr, RESET_PC);
      check("rst_valid", 32'(ifid.ifid_valid), 32'd0);
      check("rst_instr", ifid.ifid_instr, 32'd0);
      check("rst_pc",    ifid.ifid_pc, 32'd0);
      check("rst_plus4", ifid.ifid_pc_plus4, 32'd0);
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst_n           = 1'b1;
      ifid.ifid_ready = 1'b1;
      redirect_valid  = 1'b0;
      redirect_pc     = 32'h0;
      since           = 1;
      flush_target    = RESET_PC;
      exp_pc          = RESET_PC;
      all_ready       = 1'b1;
      prev_hold       = 1'b0;
   endtask

   // One clock: sample outputs, check them, then apply the inputs for the coming edge.
   task automatic cycle(input logic rdy, input logic redir, input logic [31:0] tgt);
      logic        v;
      logic [31:0] pc;
      logic [31:0] ins;
      logic [31:0] p4;
      logic [31:0] addr;
      @(negedge clk);
      v    = ifid.ifid_valid;
      pc   = ifid.ifid_pc;
      ins  = ifid.ifid_instr;
      p4   = ifid.ifid_pc_plus4;
      addr = icache_addr;
      if (since < 1000) since++;

      if (since == 1) check("redir_addr", addr, flush_target);
      if (since == 1 || since == 2) check("flush_gap", 32'(v), 32'd0);
      if (since == 3) begin
         check("first_valid", 32'(v), 32'd1);
         check("first_pc", pc, flush_target);
      end
      if (since >= 4 && all_ready) check("no_bubble", 32'(v), 32'd1);
      if (prev_hold) begin
         check("hold_valid", 32'(v), 32'd1);
         check("hold_pc", pc, held_pc);
         check("hold_instr", ins, held_instr);
      end
      check("addr_ahead", 32'((addr - exp_pc) <= 32'(4 * DEPTH)), 32'd1);

      ifid.ifid_ready = rdy;
      redirect_valid  = redir;
      redirect_pc     = tgt;

      if (v && rdy) begin
         check("pc_order", pc, exp_pc);
         check("instr", ins, mem_word(exp_pc));
         check("pc_plus4", p4, exp_pc + 32'd4);
         $display("deliver pc=0x%08h instr=0x%08h plus4=0x%08h", pc, ins, p4);
         n_deliv++;
         exp_pc = exp_pc + 32'd4;
      end

      prev_hold  = v && !rdy;
      held_pc    = pc;
      held_instr = ins;
      if (!rdy) all_ready = 1'b0;

      if (redir) begin
         since        = 0;
         flush_target = word_align(tgt);
         exp_pc       = flush_target;
         all_ready    = 1'b1;
         prev_hold    = 1'b0;
      end
   endtask

   initial begin
      rst_n           = 1'b0;
      ifid.ifid_ready = 1'b0;
      redirect_valid  = 1'b0;
      redirect_pc     = 32'h0;
      exp_pc          = RESET_PC;
      flush_target    = RESET_PC;
      since           = 1000;
      all_ready       = 1'b0;
      prev_hold       = 1'b0;
      held_pc         = 32'h0;
      held_instr      = 32'h0;

      #3;
      check_reset_state();
      repeat (2) @(negedge clk);
      release_reset();

      // Straight-line streaming from reset
      repeat (10) cycle(1'b1, 1'b0, 32'h0);

      // Decode stalls three clocks, then resumes
      repeat (3) cycle(1'b0, 1'b0, 32'h0);
      repeat (6) cycle(1'b1, 1'b0, 32'h0);

      // Fill the skid buffer, redirect while full
      repeat (3) cycle(1'b0, 1'b0, 32'h0);
      cycle(1'b0, 1'b1, 32'h0000_0040);
      repeat (6) cycle(1'b1, 1'b0, 32'h0);

      // Misaligned target, then target at the top of memory
      cycle(1'b1, 1'b1, 32'h0000_0033);
      repeat (6) cycle(1'b1, 1'b0, 32'h0);
      cycle(1'b1, 1'b1, 32'hFFFF_FFFC);
      repeat (6) cycle(1'b1, 1'b0, 32'h0);

      for (int i = 0; i < 2000; i++) begin
         logic        r;
         logic        d;
         logic [31:0] t;
         r = ($urandom_range(0, 99) < 70);
         d = ($urandom_range(0, 99) < 5);
         case ($urandom_range(0, 3))
            0:       t = 32'h0000_0040;
            1:       t = 32'h0000_0033;
            2:       t = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            default: t = $urandom;
         endcase
         cycle(r, d, t);
      end

      // Asynchronous reset in the middle of a stream
      repeat (5) cycle(1'b1, 1'b0, 32'h0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_state();
      @(negedge clk);
      release_reset();
      repeat (10) cycle(1'b1, 1'b0, 32'h0);

      check("progress", 32'(n_deliv > 300), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
